// File: rtl/cursor_pkg.sv
// Shared op codes and FSM encoding for the cursor controller, the input
// decoder and the board/elimination engine.
package cursor_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SELECT  = 3'd1;
  localparam logic [2:0] OP_CANCEL  = 3'd2;
  localparam logic [2:0] OP_LEFT    = 3'd3;
  localparam logic [2:0] OP_RIGHT   = 3'd4;
  localparam logic [2:0] OP_UP      = 3'd5;
  localparam logic [2:0] OP_DOWN    = 3'd6;
  localparam logic [2:0] OP_CONFIRM = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    ELIM = 2'd2
  } state_t;

endpackage

// File: rtl/coord_step.sv
// One-axis cursor step: increment or decrement a coordinate inside
// 0..LIMIT-1, either saturating at the edges or wrapping around.
module coord_step #(
  parameter int LIMIT   = 8,
  parameter int COORD_W = 4,
  parameter int WRAP    = 0
) (
  input  logic [COORD_W-1:0] coord,
  input  logic               inc,
  input  logic               dec,
  output logic [COORD_W-1:0] next
);

  // Edge compare runs one bit wider so a non power-of-two LIMIT never
  // aliases onto a smaller coordinate.
  localparam logic [COORD_W:0] MAX = (COORD_W+1)'(LIMIT - 1);

  logic [COORD_W:0] ext;

  // Next coordinate; below MAX the +1 cannot overflow COORD_W bits.
  always_comb begin
    ext  = {1'b0, coord};
    next = coord;
    if (inc) begin
      if (ext >= MAX) next = (WRAP != 0) ? '0 : MAX[COORD_W-1:0];
      else            next = coord + 1'b1;
    end else if (dec) begin
      if (ext == '0)  next = (WRAP != 0) ? MAX[COORD_W-1:0] : '0;
      else            next = coord - 1'b1;
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor and selection controller: moves a cursor over the grid, locks a
// selection and holds an elimination request until the board acknowledges.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int COORD_W = 4,
  parameter int WRAP    = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [2:0]         op,
  output logic               op_ready,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               selected,
  output logic [COORD_W-1:0] sel_x,
  output logic [COORD_W-1:0] sel_y,
  output logic               elim_req,
  output logic [COORD_W-1:0] elim_x,
  output logic [COORD_W-1:0] elim_y,
  input  logic               elim_ack,
  output logic [CNT_W-1:0]   elim_cnt
);

  state_t             state, state_n;
  logic               accept;
  logic [COORD_W-1:0] step_x, step_y;
  logic [COORD_W-1:0] cur_x_n, cur_y_n, sel_x_n, sel_y_n, elim_x_n, elim_y_n;
  logic               selected_n, elim_req_n, op_ready_n;
  logic [CNT_W-1:0]   elim_cnt_n;

  assign accept = op_valid && op_ready;

  coord_step #(.LIMIT(GRID_W), .COORD_W(COORD_W), .WRAP(WRAP)) u_step_x (
    .coord (cur_x),
    .inc   (op == OP_RIGHT),
    .dec   (op == OP_LEFT),
    .next  (step_x)
  );

  coord_step #(.LIMIT(GRID_H), .COORD_W(COORD_W), .WRAP(WRAP)) u_step_y (
    .coord (cur_y),
    .inc   (op == OP_DOWN),
    .dec   (op == OP_UP),
    .next  (step_y)
  );

  // Next-state and next-output logic; everything holds unless an accepted
  // op or an ack in ELIM says otherwise.
  always_comb begin
    state_n    = state;
    cur_x_n    = cur_x;
    cur_y_n    = cur_y;
    sel_x_n    = sel_x;
    sel_y_n    = sel_y;
    selected_n = selected;
    elim_req_n = elim_req;
    elim_x_n   = elim_x;
    elim_y_n   = elim_y;
    elim_cnt_n = elim_cnt;
    unique case (state)
      IDLE: if (accept) begin
        case (op)
          OP_LEFT, OP_RIGHT: cur_x_n = step_x;
          OP_UP, OP_DOWN:    cur_y_n = step_y;
          OP_SELECT: begin
            sel_x_n    = cur_x;
            sel_y_n    = cur_y;
            selected_n = 1'b1;
            state_n    = SEL;
          end
          default: ;
        endcase
      end
      SEL: if (accept) begin
        case (op)
          OP_CANCEL: begin
            selected_n = 1'b0;
            state_n    = IDLE;
          end
          OP_CONFIRM: begin
            elim_x_n   = sel_x;
            elim_y_n   = sel_y;
            elim_req_n = 1'b1;
            state_n    = ELIM;
          end
          default: ;
        endcase
      end
      ELIM: if (elim_ack) begin
        elim_req_n = 1'b0;
        selected_n = 1'b0;
        if (elim_cnt != '1) elim_cnt_n = elim_cnt + 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    op_ready_n = (state_n != ELIM);
  end

  // State and output registers; op_ready is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_ready <= 1'b1;
      cur_x    <= '0;
      cur_y    <= '0;
      sel_x    <= '0;
      sel_y    <= '0;
      selected <= 1'b0;
      elim_req <= 1'b0;
      elim_x   <= '0;
      elim_y   <= '0;
      elim_cnt <= '0;
    end else begin
      state    <= state_n;
      op_ready <= op_ready_n;
      cur_x    <= cur_x_n;
      cur_y    <= cur_y_n;
      sel_x    <= sel_x_n;
      sel_y    <= sel_y_n;
      selected <= selected_n;
      elim_req <= elim_req_n;
      elim_x   <= elim_x_n;
      elim_y   <= elim_y_n;
      elim_cnt <= elim_cnt_n;
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: two configurations share one stimulus stream
// (default saturating 8x8, and a wrapping 6x5 grid with a 2-bit counter)
// and are compared against a behavioural model of the board cursor.
module tb_cursor_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic op_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic elim_ack = 1'b0;

  logic          op_ready [2];
  logic [CW-1:0] cur_x [2], cur_y [2], sel_x [2], sel_y [2], elim_x [2], elim_y [2];
  logic          selected [2], elim_req [2];
  logic [15:0]   cnt0, cnt1;
  logic [1:0]    cnt_small;
  assign cnt1 = {14'd0, cnt_small};

  always #5 clk = ~clk;

  cursor_ctrl #(.GRID_W(8), .GRID_H(8), .COORD_W(CW), .WRAP(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready[0]),
    .cur_x(cur_x[0]), .cur_y(cur_y[0]), .selected(selected[0]), .sel_x(sel_x[0]),
    .sel_y(sel_y[0]), .elim_req(elim_req[0]), .elim_x(elim_x[0]), .elim_y(elim_y[0]),
    .elim_ack(elim_ack), .elim_cnt(cnt0)
  );

  cursor_ctrl #(.GRID_W(6), .GRID_H(5), .COORD_W(CW), .WRAP(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready[1]),
    .cur_x(cur_x[1]), .cur_y(cur_y[1]), .selected(selected[1]), .sel_x(sel_x[1]),
    .sel_y(sel_y[1]), .elim_req(elim_req[1]), .elim_x(elim_x[1]), .elim_y(elim_y[1]),
    .elim_ack(elim_ack), .elim_cnt(cnt_small)
  );

  // Reference model: board configuration and the expected board cursor.
  int W [2]    = '{8, 6};
  int H [2]    = '{8, 5};
  int WR [2]   = '{0, 1};
  int CMAX [2] = '{65535, 3};
  int m_phase;  // 0 free cursor, 1 selection held, 2 waiting for the board
  bit m_sel, m_req;
  int m_x [2], m_y [2], m_sx [2], m_sy [2], m_ex [2], m_ey [2], m_cnt [2];

  int n_chk = 0;
  int n_err = 0;

  function automatic int mv(int c, int lim, int wr, int dir);
    int r;
    r = c + dir;
    if (wr != 0) r = (r + lim) % lim;
    else if (r < 0) r = 0;
    else if (r > lim - 1) r = lim - 1;
    return r;
  endfunction

  function automatic logic [15:0] get_cnt(int d);
    return (d == 0) ? cnt0 : cnt1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_req = 0;
    for (int d = 0; d < 2; d++) begin
      m_x[d] = 0; m_y[d] = 0; m_sx[d] = 0; m_sy[d] = 0;
      m_ex[d] = 0; m_ey[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // Drive one cycle of inputs, then advance the model and sample 1ns after the edge.
  task automatic apply(input bit v, input logic [2:0] o, input bit a);
    @(negedge clk);
    op_valid = v; op = o; elim_ack = a;
    @(posedge clk);
    if (m_phase == 0 && v) begin
      for (int d = 0; d < 2; d++) begin
        if (o == 3) m_x[d] = mv(m_x[d], W[d], WR[d], -1);
        if (o == 4) m_x[d] = mv(m_x[d], W[d], WR[d], 1);
        if (o == 5) m_y[d] = mv(m_y[d], H[d], WR[d], -1);
        if (o == 6) m_y[d] = mv(m_y[d], H[d], WR[d], 1);
        if (o == 1) begin m_sx[d] = m_x[d]; m_sy[d] = m_y[d]; end
      end
      if (o == 1) begin m_sel = 1; m_phase = 1; end
    end else if (m_phase == 1 && v) begin
      if (o == 2) begin m_sel = 0; m_phase = 0; end
      else if (o == 7) begin
        for (int d = 0; d < 2; d++) begin m_ex[d] = m_sx[d]; m_ey[d] = m_sy[d]; end
        m_req = 1; m_phase = 2;
      end
    end else if (m_phase == 2 && a) begin
      m_req = 0; m_sel = 0; m_phase = 0;
      for (int d = 0; d < 2; d++) if (m_cnt[d] < CMAX[d]) m_cnt[d]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; elim_ack = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (op_ready[d] !== 1'b1 || selected[d] !== 1'b0 || elim_req[d] !== 1'b0 ||
          cur_x[d] !== 0 || cur_y[d] !== 0 || sel_x[d] !== 0 || sel_y[d] !== 0 ||
          elim_x[d] !== 0 || elim_y[d] !== 0 || get_cnt(d) !== 0) begin
        n_err++;
        $display("FAIL reset dut%0d: ready=%b sel=%b req=%b cur=(%0d,%0d) cnt=%0d, need ready=1 rest 0",
                 d, op_ready[d], selected[d], elim_req[d], cur_x[d], cur_y[d], get_cnt(d));
      end
    end
  endtask

  task automatic test_move();
    do_reset();
    repeat (3) apply(1, 3'd4, 0);
    repeat (2) apply(1, 3'd6, 0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cur_x[d] !== 3 || cur_y[d] !== 2 || selected[d] !== 1'b0 || op_ready[d] !== 1'b1) begin
        n_err++;
        $display("FAIL move dut%0d: cur=(%0d,%0d) sel=%b ready=%b, need (3,2) 0 1",
                 d, cur_x[d], cur_y[d], selected[d], op_ready[d]);
      end
    end
  endtask

  task automatic test_edges();
    do_reset();
    apply(1, 3'd3, 0);  // LEFT at x=0
    n_chk++;
    if (cur_x[0] !== 0 || cur_x[1] !== 5 || cur_y[0] !== 0) begin
      n_err++;
      $display("FAIL edge_left: x0=%0d x1=%0d y0=%0d, need 0 5 0", cur_x[0], cur_x[1], cur_y[0]);
    end
    apply(1, 3'd4, 0);  // RIGHT from 0 (sat) / from 5 (wrap)
    n_chk++;
    if (cur_x[0] !== 1 || cur_x[1] !== 0) begin
      n_err++;
      $display("FAIL edge_right_wrap: x0=%0d x1=%0d, need 1 0", cur_x[0], cur_x[1]);
    end
    apply(1, 3'd5, 0);  // UP at y=0
    n_chk++;
    if (cur_y[0] !== 0 || cur_y[1] !== 4) begin
      n_err++;
      $display("FAIL edge_up: y0=%0d y1=%0d, need 0 4", cur_y[0], cur_y[1]);
    end
    repeat (10) apply(1, 3'd4, 0);
    repeat (10) apply(1, 3'd6, 0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cur_x[d] !== CW'(m_x[d]) || cur_y[d] !== CW'(m_y[d])) begin
        n_err++;
        $display("FAIL edge_far dut%0d: cur=(%0d,%0d), need (%0d,%0d)",
                 d, cur_x[d], cur_y[d], m_x[d], m_y[d]);
      end
    end
    n_chk++;
    if (cur_x[0] !== 7 || cur_y[0] !== 7) begin
      n_err++;
      $display("FAIL edge_sat: cur=(%0d,%0d), need (7,7)", cur_x[0], cur_y[0]);
    end
  endtask

  task automatic test_select();
    do_reset();
    repeat (4) apply(1, 3'd4, 0);
    repeat (4) apply(1, 3'd6, 0);
    apply(1, 3'd1, 0);  // SELECT
    apply(1, 3'd4, 0);  // RIGHT ignored
    apply(1, 3'd1, 0);  // SELECT ignored
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cur_x[d] !== 4 || cur_y[d] !== 4 || sel_x[d] !== 4 || sel_y[d] !== 4 || selected[d] !== 1'b1) begin
        n_err++;
        $display("FAIL select_frozen dut%0d: cur=(%0d,%0d) sel=(%0d,%0d) selected=%b, need (4,4) (4,4) 1",
                 d, cur_x[d], cur_y[d], sel_x[d], sel_y[d], selected[d]);
      end
    end
    apply(1, 3'd2, 0);  // CANCEL
    n_chk++;
    if (selected[0] !== 1'b0 || selected[1] !== 1'b0) begin
      n_err++;
      $display("FAIL cancel: selected=%b%b, need 00", selected[0], selected[1]);
    end
    apply(1, 3'd4, 0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cur_x[d] !== 5 || cur_y[d] !== 4) begin
        n_err++;
        $display("FAIL move_after_cancel dut%0d: cur=(%0d,%0d), need (5,4)", d, cur_x[d], cur_y[d]);
      end
    end
  endtask

  task automatic test_elim();
    do_reset();
    repeat (2) apply(1, 3'd4, 0);
    repeat (6) apply(1, 3'd6, 0);
    apply(1, 3'd1, 0);
    apply(1, 3'd7, 0);  // CONFIRM
    n_chk++;
    if (elim_req[0] !== 1'b1 || elim_x[0] !== 2 || elim_y[0] !== 6 || op_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL confirm: req=%b elim=(%0d,%0d) ready=%b, need 1 (2,6) 0",
               elim_req[0], elim_x[0], elim_y[0], op_ready[0]);
    end
    n_chk++;
    if (elim_req[1] !== 1'b1 || elim_x[1] !== CW'(m_ex[1]) || elim_y[1] !== CW'(m_ey[1]) || op_ready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL confirm_wrapcfg: req=%b elim=(%0d,%0d) ready=%b, need 1 (%0d,%0d) 0",
               elim_req[1], elim_x[1], elim_y[1], op_ready[1], m_ex[1], m_ey[1]);
    end
    apply(1, 3'd5, 0);  // UP while waiting
    repeat (3) apply(0, 3'd0, 0);
    n_chk++;
    if (elim_req[0] !== 1'b1 || cur_x[0] !== 2 || cur_y[0] !== 6 || elim_y[0] !== 6) begin
      n_err++;
      $display("FAIL elim_hold: req=%b cur=(%0d,%0d) elim_y=%0d, need 1 (2,6) 6",
               elim_req[0], cur_x[0], cur_y[0], elim_y[0]);
    end
    apply(0, 3'd0, 1);  // ack
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (elim_req[d] !== 1'b0 || selected[d] !== 1'b0 || get_cnt(d) !== 1 || op_ready[d] !== 1'b1) begin
        n_err++;
        $display("FAIL ack dut%0d: req=%b sel=%b cnt=%0d ready=%b, need 0 0 1 1",
                 d, elim_req[d], selected[d], get_cnt(d), op_ready[d]);
      end
    end
  endtask

  task automatic test_saturate();
    repeat (4) begin
      apply(1, 3'd1, 0);
      apply(1, 3'd7, 0);
      apply(0, 3'd0, 0);
      apply(0, 3'd0, 1);
    end
    n_chk++;
    if (cnt1 !== 16'd3 || cnt0 !== 16'(m_cnt[0])) begin
      n_err++;
      $display("FAIL cnt_saturate: small=%0d wide=%0d, need 3 %0d", cnt1, cnt0, m_cnt[0]);
    end
    apply(0, 3'd0, 1);  // ack in IDLE
    n_chk++;
    if (cnt1 !== 16'd3 || cnt0 !== 16'(m_cnt[0]) || elim_req[0] !== 1'b0 || op_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ack_idle: small=%0d wide=%0d req=%b ready=%b, need 3 %0d 0 1",
               cnt1, cnt0, elim_req[0], op_ready[0], m_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_elim();
    apply(1, 3'd4, 0);
    apply(1, 3'd1, 0);
    apply(1, 3'd7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (elim_req[0] !== 1'b0 || elim_req[1] !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_req: req=%b%b, need 00", elim_req[0], elim_req[1]);
    end
    do_reset();
    apply(0, 3'd0, 0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (op_ready[d] !== 1'b1 || cur_x[d] !== 0 || cur_y[d] !== 0 || get_cnt(d) !== 0 || selected[d] !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset dut%0d: ready=%b cur=(%0d,%0d) cnt=%0d sel=%b, need 1 (0,0) 0 0",
                 d, op_ready[d], cur_x[d], cur_y[d], get_cnt(d), selected[d]);
      end
    end
    apply(1, 3'd1, 0);  // back in IDLE: SELECT must lock
    n_chk++;
    if (selected[0] !== 1'b1 || op_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle: selected=%b ready=%b, need 1 1", selected[0], op_ready[0]);
    end
  endtask

  task automatic test_random();
    bit v, a;
    logic [2:0] o;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = 3'($urandom_range(0, 7));
      if (m_phase == 2) a = ($urandom_range(0, 2) == 0);
      else a = ($urandom_range(0, 5) == 0) && !(m_phase == 1 && v && o == 3'd7);
      apply(v, o, a);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (cur_x[d] !== CW'(m_x[d]) || cur_y[d] !== CW'(m_y[d]) || selected[d] !== m_sel ||
            elim_req[d] !== m_req || op_ready[d] !== (m_phase != 2) || get_cnt(d) !== 16'(m_cnt[d])) begin
          n_err++;
          $display("FAIL rand_state dut%0d step%0d: cur=(%0d,%0d) sel=%b req=%b rdy=%b cnt=%0d, need (%0d,%0d) %b %b %b %0d",
                   d, i, cur_x[d], cur_y[d], selected[d], elim_req[d], op_ready[d], get_cnt(d),
                   m_x[d], m_y[d], m_sel, m_req, m_phase != 2, m_cnt[d]);
        end
        if (m_sel) begin
          n_chk++;
          if (sel_x[d] !== CW'(m_sx[d]) || sel_y[d] !== CW'(m_sy[d])) begin
            n_err++;
            $display("FAIL rand_sel dut%0d step%0d: sel=(%0d,%0d), need (%0d,%0d)",
                     d, i, sel_x[d], sel_y[d], m_sx[d], m_sy[d]);
          end
        end
        if (m_req) begin
          n_chk++;
          if (elim_x[d] !== CW'(m_ex[d]) || elim_y[d] !== CW'(m_ey[d])) begin
            n_err++;
            $display("FAIL rand_elim dut%0d step%0d: elim=(%0d,%0d), need (%0d,%0d)",
                     d, i, elim_x[d], elim_y[d], m_ex[d], m_ey[d]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move();
    test_edges();
    test_select();
    test_elim();
    test_saturate();
    test_reset_mid_elim();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
- Parametrised cursor and selection controller for the tile-elimination board.
- Takes decoded player operations and moves a cursor over a GRID_W x GRID_H grid.
- Locks a selection, then issues a held elimination request to the board logic.
- Sits between the input decoder and the board/elimination engine; the board's completion drives elim_ack.

Parameters:
- GRID_W, 8, number of columns; cursor x range 0..GRID_W-1
- GRID_H, 8, number of rows; cursor y range 0..GRID_H-1
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W >= max(GRID_W, GRID_H)
- WRAP, 0, 0 = cursor saturates at edges; 1 = cursor wraps to the opposite edge
- CNT_W, 16, width of the elimination counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  op is valid this cycle
- op  in  3  0 NOP, 1 SELECT, 2 CANCEL, 3 LEFT, 4 RIGHT, 5 UP, 6 DOWN, 7 CONFIRM
- op_ready  out  1  block accepts ops; low while in ELIM
- cur_x  out  COORD_W  cursor column
- cur_y  out  COORD_W  cursor row
- selected  out  1  selection locked
- sel_x  out  COORD_W  locked column
- sel_y  out  COORD_W  locked row
- elim_req  out  1  elimination request; held until acknowledged
- elim_x  out  COORD_W  target column, stable while elim_req is high
- elim_y  out  COORD_W  target row, stable while elim_req is high
- elim_ack  in  1  board has finished the elimination
- elim_cnt  out  CNT_W  completed eliminations, saturating

Behaviour:
- Reset (clk, rst_n asynchronous active-low, fixed):
  - All outputs are 0 except op_ready = 1.
  - State is IDLE.
  - Reset mid-ELIM drops elim_req immediately; no ack is expected afterwards.
- An op is accepted when op_valid && op_ready at a rising edge. All outputs are registered; an accepted op's effect is visible 1 cycle later.
- FSM states: IDLE, SEL, ELIM.
- IDLE:
  - LEFT/RIGHT/UP/DOWN: x-1 / x+1 / y-1 / y+1.
  - SELECT: latch sel_x/sel_y from cur_x/cur_y; selected = 1; go to SEL.
  - CANCEL, CONFIRM, NOP: ignored.
- SEL:
  - Move ops and SELECT are ignored; cursor is frozen.
  - CANCEL: selected = 0; go to IDLE.
  - CONFIRM: elim_x/elim_y = sel_x/sel_y; elim_req = 1; go to ELIM.
- ELIM:
  - op_ready = 0; ops are not consumed.
  - On elim_ack: elim_req = 0, selected = 0, elim_cnt += 1 (saturating at all-ones); go to IDLE.
  - The cursor stays at the selected cell.
- elim_ack outside ELIM is ignored.
- elim_ack in the same cycle elim_req rises cannot occur: elim_req is registered, so the earliest ack is sampled 1 cycle after elim_req goes high.
- Edge handling, WRAP=0: LEFT at x=0 keeps x=0; RIGHT at GRID_W-1 keeps GRID_W-1; same rules for y.
- Edge handling, WRAP=1: LEFT at 0 gives GRID_W-1; RIGHT at GRID_W-1 gives 0; same for y with GRID_H.
- Arithmetic is done at COORD_W+1 bits before compare, so no modular aliasing occurs when the grid size is not a power of two.
- Only one op is processed per cycle. Op codes outside 0..7 are impossible by width.

Decomposition:
- Package cursor_pkg holds:
  - op-code localparams OP_NOP..OP_CONFIRM
  - state encoding IDLE/SEL/ELIM
  - shared with the input decoder and board engine
- Sub-module coord_step(LIMIT, COORD_W, WRAP):
  - Combinational one-axis inc/dec with saturate or wrap.
  - Instantiated twice, once per axis.
- The FSM and registers stay in cursor_ctrl.

Test Plan:
- Reset, then 3x RIGHT and 2x DOWN -> cur=(3,2), selected=0, op_ready=1.
- WRAP=0: LEFT at (0,0) -> (0,0). WRAP=1, GRID_W=6: LEFT at x=0 -> x=5; RIGHT at x=5 -> x=0.
- Move to (4,4), SELECT, then RIGHT -> cur stays (4,4), sel=(4,4), selected=1. Then CANCEL -> selected=0; RIGHT -> cur=(5,4).
- SELECT at (2,6), CONFIRM -> elim_req=1, elim=(2,6), op_ready=0. UP during wait -> ignored. elim_ack after 5 cycles -> elim_req=0, selected=0, elim_cnt=1, op_ready=1.
- CNT_W=2: four full confirm/ack cycles -> elim_cnt stays at 3. elim_ack pulsed in IDLE -> no change.
- Assert rst_n low while elim_req=1 -> elim_req=0 asynchronously; after release, state is IDLE, cur=(0,0), elim_cnt=0.
